// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bus: D/E/M/W pipeline register info in, forwarding
// selects, active-low stall/flush controls and event counters out.
//   master : pipeline / control unit side (drives stage info)
//   slave  : hazard_ctrl_unit side (drives FwdA/FwdB/STALL/Condep/counters)
interface hazard_ctrl_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [REG_AW-1:0] dRs;
  logic [REG_AW-1:0] dRt;
  logic              dUseRs;
  logic              dUseRt;
  logic [REG_AW-1:0] eRd;
  logic              eWreg;
  logic              eLoad;
  logic              eValid;
  logic              eRedirect;
  logic [REG_AW-1:0] mRd;
  logic              mWreg;
  logic [REG_AW-1:0] wRd;
  logic              wWreg;
  logic [1:0]        FwdA;
  logic [1:0]        FwdB;
  logic              STALL;
  logic              Condep;
  logic [CNT_W-1:0]  StallCnt;
  logic [CNT_W-1:0]  FlushCnt;

  modport master (
    output dRs, dRt, dUseRs, dUseRt, eRd, eWreg, eLoad, eValid, eRedirect,
           mRd, mWreg, wRd, wWreg,
    input  FwdA, FwdB, STALL, Condep, StallCnt, FlushCnt
  );

  modport slave (
    input  dRs, dRt, dUseRs, dUseRt, eRd, eWreg, eLoad, eValid, eRedirect,
           mRd, mWreg, wRd, wWreg,
    output FwdA, FwdB, STALL, Condep, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Standalone hazard controller for the 5-stage pipeline.
//   Clk  : pipeline clock, rising edge
//   Clrn : asynchronous active-low reset
//   bus  : hazard_ctrl_unit_if.slave
//          in : dRs/dRt/dUseRs/dUseRt, eRd/eWreg/eLoad/eValid/eRedirect,
//               mRd/mWreg, wRd/wWreg
//          out: FwdA/FwdB (00 regfile, 10 E, 01 M, 11 W), STALL (active-low
//               PC/IF-ID hold + E bubble), Condep (active-low IF/ID kill),
//               StallCnt/FlushCnt (saturating event counters)
// Optional macro HAZ_WB_FWD_EN: enables W-stage forwarding (select 11) for
// register files without write-before-read; otherwise wRd/wWreg are unused.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned FLUSH_SLOTS = 1,
  parameter int unsigned CNT_W       = 16
) (
  input logic              Clk,
  input logic              Clrn,
  hazard_ctrl_unit_if.slave bus
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0]    LSTALL_INIT = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0]    FLUSH_INIT  = CW'(FLUSH_SLOTS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam bit               LSTALL_EN   = (LOAD_LAT > 1);
  localparam bit               FLUSH_EN    = (FLUSH_SLOTS > 1);

  typedef enum logic [1:0] {IDLE, LSTALL, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic e_rs, e_rt, m_rs, m_rt;
  logic hz, rd;
  logic stall_n, condep_n;
  logic [1:0] fwd_a, fwd_b;

  // Source/destination match; register 0 is never forwarded.
  function automatic logic src_match(input logic en, input logic [REG_AW-1:0] src,
                                     input logic wreg, input logic [REG_AW-1:0] dst);
    return en & wreg & (dst != '0) & (src == dst);
  endfunction

  assign e_rs = src_match(bus.dUseRs, bus.dRs, bus.eWreg, bus.eRd);
  assign e_rt = src_match(bus.dUseRt, bus.dRt, bus.eWreg, bus.eRd);
  assign m_rs = src_match(bus.dUseRs, bus.dRs, bus.mWreg, bus.mRd);
  assign m_rt = src_match(bus.dUseRt, bus.dRt, bus.mWreg, bus.mRd);

`ifdef HAZ_WB_FWD_EN
  logic w_rs, w_rt;
  assign w_rs = src_match(bus.dUseRs, bus.dRs, bus.wWreg, bus.wRd);
  assign w_rt = src_match(bus.dUseRt, bus.dRt, bus.wWreg, bus.wRd);
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wRd, bus.wWreg};
`endif

  // Load result is not ready in E, so an E load falls through to M/W.
  assign hz = bus.eValid & bus.eLoad & (e_rs | e_rt);
  assign rd = bus.eValid & bus.eRedirect;

  // Forwarding mux: later assignments take priority (E > M > W).
  always_comb begin : fwd_mux
    fwd_a = 2'b00;
    fwd_b = 2'b00;
`ifdef HAZ_WB_FWD_EN
    if (w_rs) fwd_a = 2'b11;
    if (w_rt) fwd_b = 2'b11;
`endif
    if (m_rs) fwd_a = 2'b01;
    if (m_rt) fwd_b = 2'b01;
    if (e_rs && !bus.eLoad) fwd_a = 2'b10;
    if (e_rt && !bus.eLoad) fwd_b = 2'b10;
  end

  // State register and counters.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state and Mealy controls; a redirect wins over a load-use hazard
  // because the dependent instruction is being killed anyway.
  always_comb begin : fsm_next
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_n     = 1'b1;
    condep_n    = 1'b1;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rd) begin
          condep_n = 1'b0;
          if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
          if (FLUSH_EN) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end else if (hz) begin
          stall_n = 1'b0;
          if (LSTALL_EN) begin
            state_d = LSTALL;
            cnt_d   = LSTALL_INIT;
          end
        end
      end
      LSTALL: begin
        stall_n = 1'b0;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      FLUSH: begin
        condep_n = 1'b0;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    stall_cnt_d = stall_cnt_q;
    if (!stall_n && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Controls forced inactive while reset is held.
  assign bus.STALL    = stall_n | ~Clrn;
  assign bus.Condep   = condep_n | ~Clrn;
  assign bus.FwdA     = Clrn ? fwd_a : 2'b00;
  assign bus.FwdB     = Clrn ? fwd_b : 2'b00;
  assign bus.StallCnt = stall_cnt_q;
  assign bus.FlushCnt = flush_cnt_q;

endmodule
